// File: rtl/key_bit_encoder.sv
// Purpose : debounce two active-low keys (k1 = bit 1, k2 = bit 0) into single accepted bits.
// Latency : DEBOUNCE_CYCLES+3 cycles from the first edge sampling a stable press to bit_valid.
// Backpr. : bit_valid/bit_value hold until bit_ready; key activity during the offer is ignored.
//
// Ports:
//   CLOCK_50  - system clock, rising edge
//   rst       - synchronous active-high reset
//   k1, k2    - raw asynchronous keys, active-low
//   bit_valid - an accepted bit is offered
//   bit_value - offered bit (1 for k1, 0 for k2)
//   bit_ready - consumer takes the offered bit when high together with bit_valid
//   history   - accepted bits, newest in bit 0
//   busy      - high whenever the FSM is not IDLE
//
// Optional feature: define KEY_HISTORY_EN to build the history shift register;
// without it, history is tied to zero.
module key_bit_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIST_LEN        = 20
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                k1,
    input  logic                k2,
    output logic                bit_valid,
    output logic                bit_value,
    input  logic                bit_ready,
    output logic [HIST_LEN-1:0] history,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        OFFER    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

    // Two-flop synchronizers; reset to 1 so the keys read as released.
    logic [1:0] k1_sync;
    logic [1:0] k2_sync;
    logic       k1_s;
    logic       k2_s;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            k1_sync <= 2'b11;
            k2_sync <= 2'b11;
        end else begin
            k1_sync <= {k1_sync[0], k1};
            k2_sync <= {k2_sync[0], k2};
        end
    end

    assign k1_s = k1_sync[1];
    assign k2_s = k2_sync[1];

    state_t      state, next_state;
    logic [19:0] cnt, next_cnt;
    logic        next_value;
    logic        next_valid;
    logic        transfer;
    logic        cand_low;
    logic        other_low;
    logic [19:0] cnt_inc;

    // bit_value doubles as the candidate latch: it is set on the press and
    // left untouched until the next press, so it is stable through OFFER.
    assign cand_low  = bit_value ? ~k1_s : ~k2_s;
    assign other_low = bit_value ? ~k2_s : ~k1_s;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 20'd1;
    assign transfer  = (state == OFFER) && bit_valid && bit_ready;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_value <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            bit_value <= next_value;
            bit_valid <= next_valid;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_value = bit_value;
        next_valid = 1'b0;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (!k1_s && !k2_s) begin
                    next_state = RELEASE;
                end else if (!k1_s) begin
                    next_state = DEBOUNCE;
                    next_value = 1'b1;
                end else if (!k2_s) begin
                    next_state = DEBOUNCE;
                    next_value = 1'b0;
                end
            end
            DEBOUNCE: begin
                if (!cand_low) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (other_low) begin
                    next_state = RELEASE;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // bit_valid rises one cycle after entering OFFER.
                    next_state = OFFER;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                end
            end
            OFFER: begin
                if (transfer) begin
                    next_state = RELEASE;
                    next_cnt   = '0;
                end else begin
                    next_valid = 1'b1;
                end
            end
            RELEASE: begin
                if (k1_s && k2_s) begin
                    if (cnt == CNT_LAST) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt_inc;
                    end
                end else begin
                    next_cnt = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef KEY_HISTORY_EN
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            history <= '0;
        end else if (transfer) begin
            history <= {history[HIST_LEN-2:0], bit_value};
        end
    end
`else
    assign history = '0;
`endif

endmodule

// File: tb/tb_key_bit_encoder.sv
// Purpose : self-checking bench for key_bit_encoder with DEBOUNCE_CYCLES=4, HIST_LEN=20.
// Latency : expects bit_valid exactly 7 edges after the first edge sampling a stable press.
// Backpr. : scoreboard queue holds expected bits; every transfer pops and compares one.
module tb_key_bit_encoder;

    localparam int DEB  = 4;
    localparam int HLEN = 20;
`ifdef KEY_HISTORY_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    logic            CLOCK_50 = 1'b0;
    logic            rst;
    logic            k1;
    logic            k2;
    logic            bit_valid;
    logic            bit_value;
    logic            bit_ready;
    logic [HLEN-1:0] history;
    logic            busy;

    key_bit_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .HIST_LEN       (HLEN)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .k1       (k1),
        .k2       (k2),
        .bit_valid(bit_valid),
        .bit_value(bit_value),
        .bit_ready(bit_ready),
        .history  (history),
        .busy     (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int tests  = 0;
    int failed = 0;

    bit        exp_q[$];
    logic [HLEN-1:0] exp_hist = '0;
    bit        hist_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: sample half a cycle before the edge, after inputs settle.
    always begin
        bit b;
        @(negedge CLOCK_50);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_hist     = '0;
            hist_pending = 1'b0;
        end else begin
            if (hist_pending) begin
                hist_pending = 1'b0;
                check("hist_after_xfer", 32'(history), HIST_EN ? 32'(exp_hist) : 32'd0);
            end
            if (bit_valid && bit_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_xfer: got bit %0d expected no transfer at %0t",
                             bit_value, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("xfer_value", 32'(bit_value), 32'(b));
                    exp_hist     = {exp_hist[HLEN-2:0], b};
                    hist_pending = 1'b1;
                end
            end
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bit_valid && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 32'(bit_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        bit              use_k1;
        int              ready_lag;
        bit              exp_bit;
        logic [HLEN-1:0] exp_hist;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{use_k1: 1'b1, ready_lag: 3, exp_bit: 1'b1, exp_hist: 20'h00001};
        vecs[1] = '{use_k1: 1'b0, ready_lag: 0, exp_bit: 1'b0, exp_hist: 20'h00002};
        vecs[2] = '{use_k1: 1'b1, ready_lag: 5, exp_bit: 1'b1, exp_hist: 20'h00005};

        rst = 1'b1; k1 = 1'b1; k2 = 1'b1; bit_ready = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_valid", 32'(bit_valid), 32'd0);
        check("rst_value", 32'(bit_value), 32'd0);
        check("rst_hist",  32'(history),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        @(negedge CLOCK_50);

        // Stable k1 press, ready tied high: valid at edge 7 for one cycle.
        bit_ready = 1'b1;
        exp_q.push_back(1'b1);
        k1 = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            @(negedge CLOCK_50);
            if (e == 6) check("a_valid_e6", 32'(bit_valid), 32'd0);
            if (e == 7) begin
                check("a_valid_e7", 32'(bit_valid), 32'd1);
                check("a_value_e7", 32'(bit_value), 32'd1);
            end
            if (e == 8) begin
                check("a_valid_e8", 32'(bit_valid), 32'd0);
                check("a_busy_e8",  32'(busy),      32'd1);
            end
        end
        k1 = 1'b1;
        wait_idle("a_idle");

        // k2 bounce: low 2, high 1, then held low; valid 7 edges after edge 3.
        exp_q.push_back(1'b0);
        k2 = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        k2 = 1'b1;
        @(negedge CLOCK_50);
        k2 = 1'b0;
        for (int e = 3; e <= 10; e++) begin
            @(negedge CLOCK_50);
            if (e < 10) check("b_no_valid", 32'(bit_valid), 32'd0);
            if (e == 10) begin
                check("b_valid_e10", 32'(bit_valid), 32'd1);
                check("b_value_e10", 32'(bit_value), 32'd0);
            end
        end
        @(negedge CLOCK_50);
        k2 = 1'b1;
        wait_idle("b_idle");

        // Both keys together: never a bit; IDLE after 4 both-high cycles.
        k1 = 1'b0; k2 = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            @(negedge CLOCK_50);
            check("c_no_valid", 32'(bit_valid), 32'd0);
            if (e == 2) check("c_busy_release", 32'(busy), 32'd1);
        end
        k1 = 1'b1; k2 = 1'b1;
        for (int r = 0; r <= 5; r++) begin
            @(negedge CLOCK_50);
            if (r == 4) check("c_busy_r4", 32'(busy), 32'd1);
            if (r == 5) check("c_idle_r5", 32'(busy), 32'd0);
        end

        // Backpressure: offer held 10 cycles, k2 pressed meanwhile is dropped.
        bit_ready = 1'b0;
        exp_q.push_back(1'b1);
        k1 = 1'b0;
        wait_valid("d_valid");
        k2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            check("d_hold_valid", 32'(bit_valid), 32'd1);
            check("d_hold_value", 32'(bit_value), 32'd1);
        end
        bit_ready = 1'b1;
        @(negedge CLOCK_50);
        check("d_after_xfer", 32'(bit_valid), 32'd0);
        k1 = 1'b1; k2 = 1'b1;
        wait_idle("d_idle");
        repeat (10) @(negedge CLOCK_50);
        check("d_no_second", 32'(bit_valid), 32'd0);

        // Table-driven sequence 1,0,1 from a cleared history.
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        check("t_hist_clear", 32'(history), 32'd0);
        for (int v = 0; v < 3; v++) begin
            bit_ready = 1'b0;
            exp_q.push_back(vecs[v].exp_bit);
            if (vecs[v].use_k1) k1 = 1'b0;
            else                k2 = 1'b0;
            wait_valid("t_valid");
            check("t_value", 32'(bit_value), 32'(vecs[v].exp_bit));
            repeat (vecs[v].ready_lag) @(negedge CLOCK_50);
            check("t_still_valid", 32'(bit_valid), 32'd1);
            bit_ready = 1'b1;
            @(negedge CLOCK_50);
            check("t_valid_drop", 32'(bit_valid), 32'd0);
            bit_ready = 1'b0;
            k1 = 1'b1; k2 = 1'b1;
            @(negedge CLOCK_50);
            check("t_hist", 32'(history), HIST_EN ? 32'(vecs[v].exp_hist) : 32'd0);
            wait_idle("t_idle");
        end

        // Reset during a fourth offer drops it; held key is a fresh press after.
        k2 = 1'b0;
        exp_q.push_back(1'b0);
        wait_valid("r_valid");
        rst = 1'b1;
        @(negedge CLOCK_50);
        check("r_valid_drop", 32'(bit_valid), 32'd0);
        check("r_hist_zero",  32'(history),   32'd0);
        check("r_busy_zero",  32'(busy),      32'd0);
        rst = 1'b0;
        exp_q.push_back(1'b0);
        bit_ready = 1'b1;
        wait_valid("r_repress_valid");
        check("r_repress_value", 32'(bit_value), 32'd0);
        @(negedge CLOCK_50);
        k2 = 1'b1;
        wait_idle("r_idle");

        repeat (3) @(negedge CLOCK_50);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/key_bit_encoder.md
KEY_BIT_ENCODER -- requirements
Module: key_bit_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, number of stable cycles (10 ms at 50 MHz) needed to accept a press or release; legal range 2..2^20-1.
REQ-002 SHALL have parameter HIST_LEN, default 20, width of the bit history.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port k1  input  1  raw asynchronous key, active-low, meaning bit 1.
REQ-007 SHALL have port k2  input  1  raw asynchronous key, active-low, meaning bit 0.
REQ-008 SHALL have port bit_valid  output  1  an accepted bit is offered.
REQ-009 SHALL have port bit_value  output  1  offered bit: 1 for k1, 0 for k2.
REQ-010 SHALL have port bit_ready  input  1  consumer (predictor) accepts the offered bit.
REQ-011 SHALL have port history  output  HIST_LEN  accepted bits, newest in bit 0.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass k1 and k2 each through a two-flop synchronizer before any other use.
REQ-014 SHALL implement states IDLE, DEBOUNCE, OFFER and RELEASE.
REQ-015 IDLE: exactly one synchronized key low -> DEBOUNCE, latch candidate bit, clear counter; both low -> RELEASE, no event.
REQ-016 DEBOUNCE: counter increments while the candidate key stays low and the other key stays high.
REQ-017 DEBOUNCE: candidate key high -> IDLE; other key low -> RELEASE; no event in either case.
REQ-018 DEBOUNCE: counter reaching DEBOUNCE_CYCLES-1 -> OFFER with bit_valid high on the next cycle.
REQ-019 Stable press latency SHALL be exactly DEBOUNCE_CYCLES+3 cycles from the first rising edge sampling the raw key low to bit_valid high.
REQ-020 OFFER: bit_valid high and bit_value stable until a cycle with bit_valid and bit_ready both high (transfer).
REQ-021 The transfer cycle SHALL be the last cycle bit_valid is high; the next state is RELEASE.
REQ-022 OFFER: key activity SHALL be ignored; no second bit is queued.
REQ-023 bit_ready while bit_valid is low SHALL have no effect.
REQ-024 RELEASE: counter counts while both synchronized keys are high and clears on any low sample.
REQ-025 RELEASE: DEBOUNCE_CYCLES consecutive both-high cycles -> IDLE, so one press yields at most one bit.
REQ-026 The counter SHALL be 20 bits wide and SHALL saturate, never wrap.
REQ-027 On each transfer, history SHALL become {history[HIST_LEN-2:0], bit_value}; the oldest bit is discarded.

Reset
REQ-028 rst high SHALL force IDLE, counter 0, synchronizer flops 1 (keys released), bit_valid 0, bit_value 0, history 0, busy 0 on the next edge.
REQ-029 rst asserted mid-operation (including OFFER) SHALL drop the pending bit with no transfer and no history update.
REQ-030 After rst deasserts, a key already held low SHALL be treated as a new press.

Configuration
REQ-031 Macro KEY_HISTORY_EN defined: history SHALL behave per REQ-027.
REQ-032 KEY_HISTORY_EN undefined: history SHALL be constant 0, its register SHALL not be synthesized, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, HIST_LEN=20, KEY_HISTORY_EN defined unless stated)
REQ-033 k1 low held from edge 0, bit_ready tied high -> bit_valid=1, bit_value=1 at edge 7 for exactly one cycle; history=20'h00001.
REQ-034 k2 pulses low 2 cycles, high 1 cycle, then holds low -> no bit_valid during the bounce; bit_valid with bit_value=0 exactly 7 cycles after the final low sample.
REQ-035 k1 and k2 go low on the same edge and are held -> bit_valid stays 0; state reaches RELEASE; IDLE only after 4 both-high cycles.
REQ-036 k1 accepted with bit_ready low for 10 cycles, k2 pressed meanwhile -> bit_valid=1 and bit_value=1 stay stable all 10 cycles; one transfer when bit_ready rises; the k2 press is never offered.
REQ-037 Bits 1,0,1 transferred in order -> history=20'h00005; rst pulsed during a fourth OFFER -> bit_valid=0 and history=0 on the next edge.
REQ-038 Same stimulus as REQ-037 with KEY_HISTORY_EN undefined -> identical bit_valid/bit_value trace; history=0 throughout.
